// File: rtl/div_pkg.sv
// Shared widths, state codes and handshake levels for the EX-stage divider.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement magnitude of an operand when signed division is selected.
    function automatic logic [RegBus-1:0] magnitude(input logic [RegBus-1:0] v,
                                                    input logic              isSigned);
        return (isSigned && v[RegBus-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, returning {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [DoubleRegBus:0]   work_q, work_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    negQuot_q, negQuot_d;
    logic                    negRem_q, negRem_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [RegBus:0]         trial;
    logic [RegBus-1:0]       quotient;
    logic [RegBus-1:0]       remainder;

    // Working register: [64:33] partial remainder, [32:1] dividend bits not yet
    // consumed, low end collects quotient bits as they shift in.
    assign trial     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quotient  = negQuot_q ? -work_q[31:0] : work_q[31:0];
    assign remainder = negRem_q ? -work_q[64:33] : work_q[64:33];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        work_d    = {32'b0, magnitude(opdata1_i, signed_div_i), 1'b0};
                        divisor_d = magnitude(opdata2_i, signed_div_i);
                        negQuot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        negRem_d  = signed_div_i & opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    work_d   = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != 6'd32) begin
                    if (trial[RegBus]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {trial[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    cnt_d    = '0;
                    result_d = {remainder, quotient};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
